// File: rtl/alu_mul_seq.sv
// Sequential 32x32 shift-and-add multiplier (low 32 bits) that borrows the datapath ALU.
// Optional macro ALU_MUL_SEQ_EARLY_EXIT_EN: stop iterating once the remaining multiplier is zero.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | ready for start; ALU port idle
// ADD    | acc <= acc + mcand through the ALU
// SHL    | mcand <= mcand << 1 through the ALU
// SHR    | mplier <= mplier >> 1 through the ALU; count the iteration
// DONE   | product valid, one-cycle done pulse
module alu_mul_seq #(
   parameter logic [3:0] OP_ADD = 4'b1100,
   parameter logic [3:0] OP_SLL = 4'b0000,
   parameter logic [3:0] OP_SRL = 4'b0010
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        ready,
   output logic        busy,
   output logic        done,
   output logic [31:0] product,
   output logic [3:0]  alu_op,
   output logic [31:0] alu_in1,
   output logic [31:0] alu_in2,
   output logic [4:0]  alu_shamt,
   input  logic [31:0] alu_out
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_ADD  = 3'd1,
      S_SHL  = 3'd2,
      S_SHR  = 3'd3,
      S_DONE = 3'd4
   } state_e;

   state_e      state_q, state_d;
   logic [31:0] mcand_q, mcand_d;
   logic [31:0] mplier_q, mplier_d;
   logic [31:0] acc_q, acc_d;
   logic [31:0] product_q, product_d;
   logic [4:0]  cnt_q, cnt_d;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         mcand_q   <= '0;
         mplier_q  <= '0;
         acc_q     <= '0;
         product_q <= '0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         mcand_q   <= mcand_d;
         mplier_q  <= mplier_d;
         acc_q     <= acc_d;
         product_q <= product_d;
         cnt_q     <= cnt_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      mcand_d   = mcand_q;
      mplier_d  = mplier_q;
      acc_d     = acc_q;
      product_d = product_q;
      cnt_d     = cnt_q;
      alu_op    = OP_ADD;
      alu_in1   = '0;
      alu_in2   = '0;
      alu_shamt = '0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               mcand_d  = a;
               mplier_d = b;
               acc_d    = '0;
               cnt_d    = '0;
`ifdef ALU_MUL_SEQ_EARLY_EXIT_EN
               if (b == 32'd0) begin
                  state_d   = S_DONE;
                  product_d = '0;
               end else begin
                  state_d = b[0] ? S_ADD : S_SHL;
               end
`else
               state_d = b[0] ? S_ADD : S_SHL;
`endif
            end
         end
         S_ADD: begin
            alu_op  = OP_ADD;
            alu_in1 = acc_q;
            alu_in2 = mcand_q;
            acc_d   = alu_out;
            state_d = S_SHL;
         end
         S_SHL: begin
            alu_op    = OP_SLL;
            alu_in1   = mcand_q;
            alu_shamt = 5'd1;
            mcand_d   = alu_out;
            state_d   = S_SHR;
         end
         S_SHR: begin
            alu_op    = OP_SRL;
            alu_in1   = mplier_q;
            alu_shamt = 5'd1;
            mplier_d  = alu_out;
            cnt_d     = cnt_q + 5'd1;
            // acc already holds the final sum here: any ADD for this bit ran before SHL
            if (cnt_q == 5'd31) begin
               state_d   = S_DONE;
               product_d = acc_q;
`ifdef ALU_MUL_SEQ_EARLY_EXIT_EN
            end else if (alu_out == 32'd0) begin
               state_d   = S_DONE;
               product_d = acc_q;
`endif
            end else begin
               state_d = alu_out[0] ? S_ADD : S_SHL;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign ready   = (state_q == S_IDLE);
   assign busy    = (state_q == S_ADD) || (state_q == S_SHL) || (state_q == S_SHR);
   assign done    = (state_q == S_DONE);
   assign product = product_q;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Self-checking bench for alu_mul_seq: behavioural ALU, accept/done scoreboard, vector table.
// Works with or without ALU_MUL_SEQ_EARLY_EXIT_EN defined.
module tb_alu_mul_seq;

   localparam logic [3:0] OP_ADD = 4'b1100;
   localparam logic [3:0] OP_SLL = 4'b0000;
   localparam logic [3:0] OP_SRL = 4'b0010;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [31:0] a, b;
   logic        ready, busy, done;
   logic [31:0] product;
   logic [3:0]  alu_op;
   logic [31:0] alu_in1, alu_in2;
   logic [4:0]  alu_shamt;
   logic [31:0] alu_out;

   alu_mul_seq #(.OP_ADD(OP_ADD), .OP_SLL(OP_SLL), .OP_SRL(OP_SRL)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
      .ready(ready), .busy(busy), .done(done), .product(product),
      .alu_op(alu_op), .alu_in1(alu_in1), .alu_in2(alu_in2),
      .alu_shamt(alu_shamt), .alu_out(alu_out)
   );

   always #5 clk = ~clk;

   always_comb begin
      case (alu_op)
         OP_ADD:  alu_out = alu_in1 + alu_in2;
         OP_SLL:  alu_out = alu_in1 << alu_shamt;
         OP_SRL:  alu_out = alu_in1 >> alu_shamt;
         default: alu_out = 32'd0;
      endcase
   end

   typedef struct {
      logic [31:0] prod;
      int          dcyc;
   } exp_t;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] p;
   } vec_t;

   exp_t sb_q[$];
   vec_t vecs[9];
   int   n_checks = 0;
   int   n_pass   = 0;
   int   cyc      = 0;
   int   n_acc    = 0;
   int   last_done = -1;
   bit   cont_mode = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
   endtask

   task automatic fail(input string name);
      n_checks++;
      $display("FAIL %s: event did not occur as required (cycle %0d)", name, cyc);
   endtask

   function automatic int exp_lat(input logic [31:0] bb);
      int r;
`ifdef ALU_MUL_SEQ_EARLY_EXIT_EN
      int m;
      if (bb == 32'd0) return 1;
      m = 0;
      for (int i = 0; i < 32; i++) if (bb[i]) m = i;
      r = 1;
      for (int i = 0; i <= m; i++) r += 2 + int'(bb[i]);
`else
      r = 65 + $countones(bb);
`endif
      return r;
   endfunction

   // scoreboard: push at the negedge before an accepting edge, pop on done
   always @(negedge clk) begin
      exp_t e;
      if (done === 1'b1) begin
         if (sb_q.size() == 0) fail("unexpected_done");
         else begin
            e = sb_q.pop_front();
            chk("done_cycle", cyc, e.dcyc);
            chk("sb_product", product, e.prod);
         end
         last_done = cyc;
      end else if (sb_q.size() > 0 && cyc > sb_q[0].dcyc) begin
         fail("done_timeout");
         void'(sb_q.pop_front());
      end
      if (rst_n !== 1'b1) sb_q.delete();
      else if (ready === 1'b1 && start === 1'b1) begin
         if (cont_mode && last_done >= 0) chk("b2b_accept_cycle", cyc + 1, last_done + 2);
         e.prod = a * b;
         e.dcyc = cyc + exp_lat(b);
         sb_q.push_back(e);
         n_acc++;
      end
   end

   task automatic wait_idle();
      int k = 0;
      while (sb_q.size() != 0 && k < 300) begin
         @(negedge clk);
         k++;
      end
      if (sb_q.size() != 0) fail("idle_timeout");
   endtask

   task automatic issue(input logic [31:0] aa, input logic [31:0] bb);
      int k = 0;
      @(posedge clk);
      #2;
      a = aa; b = bb; start = 1'b1;
      @(negedge clk);
      while (ready !== 1'b1 && k < 300) begin
         @(negedge clk);
         k++;
      end
      if (ready !== 1'b1) fail("ready_timeout");
      @(posedge clk);
      #2;
      start = 1'b0;
   endtask

   initial begin
      logic [3:0] ops[6];
      int acc0, k, rc;
      ops[0] = OP_ADD; ops[1] = OP_SLL; ops[2] = OP_SRL;
      ops[3] = OP_SLL; ops[4] = OP_SRL; ops[5] = OP_ADD;

      vecs[0] = '{32'd3,        32'd5,        32'd15};
      vecs[1] = '{32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFE};
      vecs[2] = '{32'h00010000, 32'h00010000, 32'h00000000};
      vecs[3] = '{32'd7,        32'd0,        32'd0};
      vecs[4] = '{32'h80000000, 32'd3,        32'h80000000};
      vecs[5] = '{32'hFFFFFFFD, 32'd7,        32'hFFFFFFEB};
      vecs[6] = '{32'd5,        32'hFFFFFFFF, 32'hFFFFFFFB};
      vecs[7] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001};
      vecs[8] = '{32'h12345678, 32'h00000010, 32'h23456780};

      rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_ready", {31'd0, ready}, 32'd1);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_product", product, 32'd0);
      chk("rst_alu_op", {28'd0, alu_op}, {28'd0, OP_ADD});
      chk("rst_alu_in1", alu_in1, 32'd0);
      chk("rst_alu_in2", alu_in2, 32'd0);
      chk("rst_alu_shamt", {27'd0, alu_shamt}, 32'd0);
      @(posedge clk);
      #2 rst_n = 1'b1;

      // a=3, b=5: ALU micro-op sequence at the start of the operation
      issue(32'd3, 32'd5);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("seq_alu_op", {28'd0, alu_op}, {28'd0, ops[i]});
         if (i == 0) begin
            chk("seq_busy", {31'd0, busy}, 32'd1);
            chk("seq_ready", {31'd0, ready}, 32'd0);
            chk("seq_add_in1", alu_in1, 32'd0);
            chk("seq_add_in2", alu_in2, 32'd3);
         end
         if (i == 1) begin
            chk("seq_shl_in1", alu_in1, 32'd3);
            chk("seq_shl_shamt", {27'd0, alu_shamt}, 32'd1);
            chk("seq_shl_in2", alu_in2, 32'd0);
         end
      end
      wait_idle();
      chk("seq_product", product, 32'd15);

      for (int i = 0; i < 9; i++) begin
         issue(vecs[i].a, vecs[i].b);
         wait_idle();
         chk("vec_product", product, vecs[i].p);
      end

      // start held high; operands change while the first operation runs
      cont_mode = 1'b1; last_done = -1; acc0 = n_acc;
      @(posedge clk);
      #2 a = 32'd11; b = 32'd13; start = 1'b1;
      k = 0;
      while (n_acc < acc0 + 1 && k < 300) begin @(posedge clk); k++; end
      if (n_acc < acc0 + 1) fail("cont_first_accept");
      repeat (10) @(posedge clk);
      #2 a = 32'd100; b = 32'd200;
      k = 0;
      while (n_acc < acc0 + 2 && k < 300) begin @(negedge clk); k++; end
      if (n_acc < acc0 + 2) fail("cont_second_accept");
      @(posedge clk);
      #2 start = 1'b0;
      wait_idle();
      chk("cont_accepts", n_acc - acc0, 32'd2);
      chk("cont_product", product, 32'd20000);
      cont_mode = 1'b0;

      // reset in the middle of a=9, b=9
`ifdef ALU_MUL_SEQ_EARLY_EXIT_EN
      rc = 6;
`else
      rc = 20;
`endif
      issue(32'd9, 32'd9);
      repeat (rc - 1) @(posedge clk);
      #2 rst_n = 1'b0;
      @(posedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk);
      chk("abort_ready", {31'd0, ready}, 32'd1);
      chk("abort_busy", {31'd0, busy}, 32'd0);
      chk("abort_done", {31'd0, done}, 32'd0);
      chk("abort_product", product, 32'd0);
      repeat (100) @(negedge clk);
      chk("abort_no_done", {31'd0, done}, 32'd0);
      issue(32'd9, 32'd9);
      wait_idle();
      chk("after_abort_product", product, 32'd81);

      repeat (3) @(posedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/alu_mul_seq.md
# alu_mul_seq

Multi-cycle 32×32 unsigned/two's-complement multiplier (low 32 bits of the product) that drives the processor's 32-bit ALU as its arithmetic engine. It issues shift-and-add micro-operations on the ALU request port (opcode, operands, shift amount) and captures the ALU's combinational result on the next clock edge. The block sits beside the datapath ALU as the initiator side of the ALU opcode interface. The ALU port is muxed in by the datapath while `busy` is high.

## Interface
- `OP_ADD`, default 4'b1100: ALU opcode for in1 + in2
- `OP_SLL`, default 4'b0000: ALU opcode for logical shift left of in1 by shAmt
- `OP_SRL`, default 4'b0010: ALU opcode for logical shift right of in1 by shAmt

- `clk`  in  1: sole clock, rising edge
- `rst_n`  in  1: synchronous, active-low reset
- `start`  in  1: request; sampled only while `ready`=1
- `a`  in  32: multiplicand, latched when start is accepted
- `b`  in  32: multiplier, latched when start is accepted
- `ready`  out  1: high in IDLE only
- `busy`  out  1: high in ADD/SHL/SHR; datapath grants ALU port to this block
- `done`  out  1: one-cycle pulse, product valid
- `product`  out  32: (a*b) mod 2^32; held until the next accepted start
- `alu_op`  out  4: opcode to ALU
- `alu_in1`  out  32: ALU operand 1
- `alu_in2`  out  32: ALU operand 2
- `alu_shamt`  out  5: ALU shift amount
- `alu_out`  in  32: ALU combinational result, same cycle

## Operation
- Registers: `mcand`, `mplier`, `acc` (32 b each); `cnt` (5 b); state ∈ {IDLE, ADD, SHL, SHR, DONE}.
- IDLE: on `start`=1, set `mcand`←a, `mplier`←b, `acc`←0, `cnt`←0. Go to ADD if b[0]=1, else to SHL.
- ADD: alu_op=OP_ADD, in1=acc, in2=mcand; `acc`←alu_out; go to SHL.
- SHL: alu_op=OP_SLL, in1=mcand, shamt=1; `mcand`←alu_out; go to SHR.
- SHR: alu_op=OP_SRL, in1=mplier, shamt=1; `mplier`←alu_out; `cnt`←cnt+1.
  - If cnt=31, go to DONE.
  - Otherwise go to ADD if alu_out[0]=1, else to SHL.
- DONE: `product`←acc is registered on entry to DONE. `done`=1 for this cycle; go to IDLE.
- In IDLE and DONE: alu_op=OP_ADD, alu_in1=alu_in2=0, alu_shamt=0. In every state, unused operands are 0.
- Arithmetic: all wraps are modulo 2^32. Signed inputs yield the correct low 32 bits. Carries out of the ALU are discarded.
- `start` is ignored outside IDLE, including in DONE. Operands are not re-sampled mid-operation.
- Reset (`rst_n`=0 at an edge), including mid-operation: state=IDLE, `mcand`=`mplier`=`acc`=`product`=0, `cnt`=0. No `done` is produced for the aborted operation.

## Timing
- Reset values: `ready`=1, `busy`=0, `done`=0, `product`=0, alu_op=OP_ADD, alu_in1=alu_in2=0, alu_shamt=0.
- Define the edge that accepts `start` as edge 0. Iteration cycles total 64+popcount(b).
- `done` is high in cycle 65+popcount(b), counted as cycles after edge 0. `ready` returns the following cycle.
- Examples: b=0 gives done at cycle 65; b=0xFFFFFFFF gives done at cycle 97.
- A back-to-back `start` is accepted in the first IDLE cycle after DONE.
- Every ALU request is combinational from state registers. The result is captured at the same edge that ends the state, so the ALU must settle within one cycle.

## Configuration
- `ALU_MUL_SEQ_EARLY_EXIT_EN` defined:
  - In SHR, if alu_out=0, go directly to DONE regardless of `cnt`.
  - In IDLE, a start with b=0 goes directly to DONE, with `product`=0 and `done` at cycle 1.
  - Latency becomes 1 + Σ over set bits up to msb(b) of (2 + bit), i.e. 2 cycles per bit position through msb(b) plus 1 per set bit, then DONE.
- Not defined: always 32 iterations; latency as in Timing. Products are identical in both builds.

## Test plan
- Reset then idle: hold rst_n=0 for 2 cycles. Require ready=1, busy=0, done=0, product=0, alu_op=OP_ADD, and all ALU operands 0.
- a=3, b=5, no macro: done at cycle 67, product=15. The sequence of alu_op values starts ADD, SHL, SRL, SHL, SRL, ADD.
- a=3, b=5, with macro: done at cycle 9, product=15. Also a=7, b=0 gives done at cycle 1, product=0.
- a=0xFFFFFFFF (−1), b=0x00000002: product=0xFFFFFFFE. Also a=0x10000, b=0x10000: product=0 (wrap). Check both builds.
- Assert start=1 continuously: exactly one operation per IDLE window. Operand changes mid-operation have no effect, and the next operation's product is correct.
- Assert rst_n=0 at cycle 20 of a=9, b=9: no done pulse, ready=1 next cycle. A subsequent a=9, b=9 gives product=81.
